// File: rtl/full_subtractor_pkg.sv
// Shared constants and result type for the registered ripple-borrow subtractor.
// Wrapper datapaths use fs_result_t to carry a difference/borrow pair as one bus.
package full_subtractor_pkg;

  localparam int FS_WIDTH_DEFAULT = 1;
  localparam int FS_WIDTH_MAX     = 64;

  typedef struct packed {
    logic [FS_WIDTH_MAX-1:0] diff;
    logic                    bout;
  } fs_result_t;

endpackage

// File: rtl/fs_cell.sv
// Purely combinational 1-bit full subtractor: d = x - y - bi, with borrow-out bo.
module fs_cell (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bout, diff} = a - b - bin, one cycle latency.
// Define FULL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef FULL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d;

  if (WIDTH < 1 || WIDTH > FS_WIDTH_MAX) begin : g_bad_width
    $error("full_subtractor: WIDTH %0d outside 1..%0d", WIDTH, FS_WIDTH_MAX);
  end

  assign br[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_cell u_cell (
      .d  (d[i]),
      .bo (br[i+1]),
      .x  (a[i]),
      .y  (b[i]),
      .bi (br[i])
    );
  end

  // Reset wins over the computed value, so X on the inputs never reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else begin
      diff <= d;
      bout <= br[WIDTH];
    end
  end

`ifdef FULL_SUBTRACTOR_OVF_EN
  // Borrow into and out of the sign bit differ exactly on two's-complement overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= br[WIDTH] ^ br[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of full_subtractor at WIDTH 1, 4, 8 and 16.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic [0:0]  a1, b1, diff1;
  logic        bin1, bout1;
  logic [3:0]  a4, b4, diff4;
  logic        bin4, bout4;
  logic [7:0]  a8, b8, diff8;
  logic        bin8, bout8;
  logic [15:0] a16, b16, diff16;
  logic        bin16, bout16;
`ifdef FULL_SUBTRACTOR_OVF_EN
  logic        ovf1, ovf4, ovf8, ovf16;
`endif

  int checks = 0;
  int passed = 0;
  logic [16:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .diff(diff1), .bout(bout1),
`ifdef FULL_SUBTRACTOR_OVF_EN
    .ovf(ovf1),
`endif
    .a(a1), .b(b1), .bin(bin1));

  full_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .diff(diff4), .bout(bout4),
`ifdef FULL_SUBTRACTOR_OVF_EN
    .ovf(ovf4),
`endif
    .a(a4), .b(b4), .bin(bin4));

  full_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .diff(diff8), .bout(bout8),
`ifdef FULL_SUBTRACTOR_OVF_EN
    .ovf(ovf8),
`endif
    .a(a8), .b(b8), .bin(bin8));

  full_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .diff(diff16), .bout(bout16),
`ifdef FULL_SUBTRACTOR_OVF_EN
    .ovf(ovf16),
`endif
    .a(a16), .b(b16), .bin(bin16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    a8 = a; b8 = b; bin8 = bin;
  endtask

  task automatic check8(input string tag, input logic [7:0] d, input logic bo);
    chk({tag, "_diff"}, 64'(diff8), 64'(d));
    chk({tag, "_bout"}, 64'(bout8), 64'(bo));
  endtask

  logic [1:0]  tt [8];
  logic [2:0]  v;
  logic [15:0] ra, rb;
  logic        rbin;
  logic [16:0] e;

  initial begin
    // Truth table as {diff, bout} indexed by {a, b, bin}.
    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

    // Reset held two cycles with unknown inputs.
    rst = 1'b1;
    a1 = 'x; b1 = 'x; bin1 = 1'bx;
    a4 = 'x; b4 = 'x; bin4 = 1'bx;
    a8 = 'x; b8 = 'x; bin8 = 1'bx;
    a16 = 'x; b16 = 'x; bin16 = 1'bx;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_diff1", 64'(diff1), 64'd0);
      chk("rst_bout1", 64'(bout1), 64'd0);
      chk("rst_diff8", 64'(diff8), 64'd0);
      chk("rst_bout8", 64'(bout8), 64'd0);
    end

    // WIDTH=1: all eight combinations, one per cycle.
    rst = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0;
    drive8(8'h00, 8'h00, 1'b0);
    a16 = '0; b16 = '0; bin16 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0];
      step();
      chk($sformatf("tt%0d_diff", i), 64'(diff1), 64'(tt[i][1]));
      chk($sformatf("tt%0d_bout", i), 64'(bout1), 64'(tt[i][0]));
    end

    // WIDTH=8 directed vectors and boundaries.
    drive8(8'h00, 8'h00, 1'b1); step(); check8("w8_zero_bin", 8'hFF, 1'b1);
`ifdef FULL_SUBTRACTOR_OVF_EN
    chk("w8_zero_bin_ovf", 64'(ovf8), 64'd0);
`endif
    drive8(8'h80, 8'h01, 1'b0); step(); check8("w8_80_01", 8'h7F, 1'b0);
`ifdef FULL_SUBTRACTOR_OVF_EN
    chk("w8_80_01_ovf", 64'(ovf8), 64'd1);
`endif
    drive8(8'h5A, 8'h5A, 1'b0); step(); check8("w8_equal", 8'h00, 1'b0);
    drive8(8'h10, 8'h20, 1'b0); step(); check8("w8_10_20", 8'hF0, 1'b1);
    drive8(8'hFF, 8'h00, 1'b0); step(); check8("w8_ones_zero", 8'hFF, 1'b0);
    drive8(8'h00, 8'hFF, 1'b1); step(); check8("w8_zero_ones", 8'h00, 1'b1);
`ifdef FULL_SUBTRACTOR_OVF_EN
    chk("w8_zero_ones_ovf", 64'(ovf8), 64'd0);
`endif

    // WIDTH=4 signed overflow case.
    a4 = 4'h7; b4 = 4'hF; bin4 = 1'b0;
    step();
    chk("w4_diff", 64'(diff4), 64'h8);
    chk("w4_bout", 64'(bout4), 64'd1);
`ifdef FULL_SUBTRACTOR_OVF_EN
    chk("w4_ovf", 64'(ovf4), 64'd1);
`endif

    // One-cycle reset mid-stream discards the vector sampled on the reset edge.
    drive8(8'h44, 8'h11, 1'b0); step(); check8("mid_pre", 8'h33, 1'b0);
    drive8(8'h33, 8'h11, 1'b0); rst = 1'b1; step(); check8("mid_rst", 8'h00, 1'b0);
    rst = 1'b0;
    drive8(8'h20, 8'h30, 1'b1); step(); check8("mid_post", 8'hEF, 1'b1);

    // WIDTH=16 back-to-back random stream through the scoreboard.
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      a16 = ra; b16 = rb; bin16 = rbin;
      exp_q.push_back({1'b0, ra} - {1'b0, rb} - 17'(rbin));
      step();
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d", i), 64'({bout16, diff16}), 64'(e));
    end

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
